// File: rtl/adpll_lock_ctrl.sv
// rtl/adpll_lock_ctrl.sv - ADPLL acquisition and lock sequencer
//
// Resets the ADPLL loop, enables it with wide gain while it acquires, and
// switches to narrow gain once the phase error has been small for long
// enough. Watches for loss of lock, a missing reference and a stuck
// acquisition, and re-sequences the loop in each case.
//
// Ports:
//   fpga_clk_i      loop clock (only clock)
//   reset_i         synchronous active-high reset
//   enable_i        master enable; low forces IDLE
//   ref_clk_i       reference clock, asynchronous, edge-detected here
//   error_i         signed ADPLL phase error, sampled on each ref tick
//   adpll_enable_o  ADPLL enable
//   adpll_reset_o   ADPLL loop reset
//   gain_sel_o      0 = wide (acquire) gain, 1 = narrow (track) gain
//   locked_o        loop locked
//   lock_lost_o     one-cycle pulse when leaving LOCKED on a fault
//   ref_missing_o   reference timeout seen; sticky until next IDLE exit
//   retry_cnt_o     acquisition timeouts since leaving IDLE, saturating
//   state_o         IDLE=0, RESET_LOOP=1, ACQUIRE=2, LOCKED=3
module adpll_lock_ctrl #(
  parameter int ERR_WIDTH     = 8,
  parameter int LOCK_THRESH   = 4,
  parameter int LOCK_COUNT    = 16,
  parameter int UNLOCK_THRESH = 16,
  parameter int UNLOCK_COUNT  = 4,
  parameter int RST_CYCLES    = 16,
  parameter int ACQ_TIMEOUT   = 4096,
  parameter int REF_TIMEOUT   = 65535
) (
  input  logic                 fpga_clk_i,
  input  logic                 reset_i,
  input  logic                 enable_i,
  input  logic                 ref_clk_i,
  input  logic [ERR_WIDTH-1:0] error_i,
  output logic                 adpll_enable_o,
  output logic                 adpll_reset_o,
  output logic                 gain_sel_o,
  output logic                 locked_o,
  output logic                 lock_lost_o,
  output logic                 ref_missing_o,
  output logic [7:0]           retry_cnt_o,
  output logic [1:0]           state_o
);

  localparam int AW = ERR_WIDTH - 1;
  localparam int RW = (RST_CYCLES   > 1) ? $clog2(RST_CYCLES)   : 1;
  localparam int GW = (LOCK_COUNT   > 1) ? $clog2(LOCK_COUNT)   : 1;
  localparam int BW = (UNLOCK_COUNT > 1) ? $clog2(UNLOCK_COUNT) : 1;
  localparam int TW = (ACQ_TIMEOUT  > 1) ? $clog2(ACQ_TIMEOUT)  : 1;
  localparam int WW = (REF_TIMEOUT  > 1) ? $clog2(REF_TIMEOUT)  : 1;

  // Counters stop one short of their limit: the transition fires when the
  // counter already holds limit-1 and one more event arrives.
  localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_COUNT - 1);
  localparam logic [BW-1:0] BAD_LAST  = BW'(UNLOCK_COUNT - 1);
  localparam logic [TW-1:0] TMR_LAST  = TW'(ACQ_TIMEOUT - 1);
  localparam logic [WW-1:0] WD_LAST   = WW'(REF_TIMEOUT - 1);
  localparam logic [AW-1:0] LOCK_T    = AW'(LOCK_THRESH);
  localparam logic [AW-1:0] UNLOCK_T  = AW'(UNLOCK_THRESH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_ACQ   = 2'd2,
    S_LOCK  = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic           sync1_q, sync2_q, hist_q;
  logic           ref_tick;
  logic [RW-1:0]  rst_cnt_q, rst_cnt_d;
  logic [GW-1:0]  good_q, good_d;
  logic [BW-1:0]  bad_q, bad_d;
  logic [TW-1:0]  tmr_q, tmr_d;
  logic [WW-1:0]  wd_q, wd_d;
  logic [7:0]     retry_q, retry_d;
  logic           miss_q, miss_d;
  logic           lost_q, lost_d;
  logic           adpll_enable_q, adpll_enable_d;
  logic           adpll_reset_q, adpll_reset_d;
  logic           gain_q, gain_d;
  logic           locked_q, locked_d;

  logic [ERR_WIDTH-1:0] err_neg;
  logic [AW-1:0]        err_abs;
  logic                 err_good, err_bad;

  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= ref_clk_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign ref_tick = sync2_q & ~hist_q;

  // Magnitude of the phase error; the most negative code has no positive
  // twin, so its negation stays negative and is clamped to all ones.
  assign err_neg = '0 - error_i;
  always_comb begin
    err_abs = error_i[AW-1:0];
    if (error_i[ERR_WIDTH-1]) begin
      if (err_neg[ERR_WIDTH-1]) err_abs = '1;
      else                      err_abs = err_neg[AW-1:0];
    end
  end

  assign err_good = (err_abs <= LOCK_T);
  assign err_bad  = (err_abs >  UNLOCK_T);

  // State and output registers
  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      state_q        <= S_IDLE;
      rst_cnt_q      <= '0;
      good_q         <= '0;
      bad_q          <= '0;
      tmr_q          <= '0;
      wd_q           <= '0;
      retry_q        <= '0;
      miss_q         <= 1'b0;
      lost_q         <= 1'b0;
      adpll_enable_q <= 1'b0;
      adpll_reset_q  <= 1'b0;
      gain_q         <= 1'b0;
      locked_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      rst_cnt_q      <= rst_cnt_d;
      good_q         <= good_d;
      bad_q          <= bad_d;
      tmr_q          <= tmr_d;
      wd_q           <= wd_d;
      retry_q        <= retry_d;
      miss_q         <= miss_d;
      lost_q         <= lost_d;
      adpll_enable_q <= adpll_enable_d;
      adpll_reset_q  <= adpll_reset_d;
      gain_q         <= gain_d;
      locked_q       <= locked_d;
    end
  end

  // Next state and counters
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    good_d    = good_q;
    bad_d     = bad_q;
    tmr_d     = tmr_q;
    wd_d      = wd_q;
    retry_d   = retry_q;
    miss_d    = miss_q;
    lost_d    = 1'b0;
    if (!enable_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d   = S_RESET;
          rst_cnt_d = '0;
          retry_d   = '0;
          miss_d    = 1'b0;
        end
        S_RESET: begin
          if (rst_cnt_q == RST_LAST) begin
            state_d = S_ACQ;
            good_d  = '0;
            tmr_d   = '0;
            wd_d    = '0;
          end else begin
            rst_cnt_d = rst_cnt_q + RW'(1);
          end
        end
        S_ACQ: begin
          // A tick always feeds the watchdog, so it cannot expire that cycle.
          if (ref_tick) begin
            wd_d = '0;
            if (err_good && good_q == GOOD_LAST) begin
              state_d = S_LOCK;
              bad_d   = '0;
            end else if (tmr_q == TMR_LAST) begin
              state_d   = S_RESET;
              rst_cnt_d = '0;
              if (retry_q != 8'hFF) retry_d = retry_q + 8'd1;
            end else begin
              good_d = err_good ? good_q + GW'(1) : '0;
              tmr_d  = tmr_q + TW'(1);
            end
          end else if (wd_q == WD_LAST) begin
            state_d   = S_RESET;
            rst_cnt_d = '0;
            miss_d    = 1'b1;
          end else begin
            wd_d = wd_q + WW'(1);
          end
        end
        S_LOCK: begin
          if (ref_tick) begin
            wd_d = '0;
            if (err_bad && bad_q == BAD_LAST) begin
              state_d = S_ACQ;
              lost_d  = 1'b1;
              good_d  = '0;
              tmr_d   = '0;
              bad_d   = '0;
            end else begin
              bad_d = err_bad ? bad_q + BW'(1) : '0;
            end
          end else if (wd_q == WD_LAST) begin
            state_d   = S_RESET;
            rst_cnt_d = '0;
            miss_d    = 1'b1;
            lost_d    = 1'b1;
          end else begin
            wd_d = wd_q + WW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs decoded from the next state so they line up with state_o.
  always_comb begin
    adpll_enable_d = 1'b0;
    adpll_reset_d  = 1'b0;
    gain_d         = 1'b0;
    locked_d       = 1'b0;
    case (state_d)
      S_RESET: adpll_reset_d = 1'b1;
      S_ACQ:   adpll_enable_d = 1'b1;
      S_LOCK: begin
        adpll_enable_d = 1'b1;
        gain_d         = 1'b1;
        locked_d       = 1'b1;
      end
      default: ;
    endcase
  end

  assign adpll_enable_o = adpll_enable_q;
  assign adpll_reset_o  = adpll_reset_q;
  assign gain_sel_o     = gain_q;
  assign locked_o       = locked_q;
  assign lock_lost_o    = lost_q;
  assign ref_missing_o  = miss_q;
  assign retry_cnt_o    = retry_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_adpll_lock_ctrl.sv
// tb/tb_adpll_lock_ctrl.sv - scoreboard bench for adpll_lock_ctrl
module tb_adpll_lock_ctrl;

  localparam int RST    = 16;
  localparam int LCNT   = 16;
  localparam int LTH    = 4;
  localparam int UTH    = 16;
  localparam int UCNT   = 4;
  localparam int ACQ_TO = 4096;
  localparam int REF_TO = 65535;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       enable_i = 1'b0;
  logic       ref_clk_i = 1'b0;
  logic [7:0] error_i = 8'd0;
  logic       adpll_enable_o, adpll_reset_o, gain_sel_o, locked_o;
  logic       lock_lost_o, ref_missing_o;
  logic [7:0] retry_cnt_o;
  logic [1:0] state_o;

  always #5 clk = ~clk;

  adpll_lock_ctrl dut (
    .fpga_clk_i     (clk),
    .reset_i        (reset_i),
    .enable_i       (enable_i),
    .ref_clk_i      (ref_clk_i),
    .error_i        (error_i),
    .adpll_enable_o (adpll_enable_o),
    .adpll_reset_o  (adpll_reset_o),
    .gain_sel_o     (gain_sel_o),
    .locked_o       (locked_o),
    .lock_lost_o    (lock_lost_o),
    .ref_missing_o  (ref_missing_o),
    .retry_cnt_o    (retry_cnt_o),
    .state_o        (state_o)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    int         cyc;
    logic [15:0] vec;
  } exp_t;
  exp_t exp_q[$];

  // Event-level reference model: absolute cycle times of the next timed
  // event plus per-tick counting of good/bad samples.
  int          m_st = 0, m_good = 0, m_bad = 0, m_tmr = 0, m_retry = 0;
  int          m_rst_end = 0, m_wd_base = 0;
  bit          m_miss = 1'b0, m_en = 1'b0;
  logic [15:0] m_last = 16'h0;

  function automatic logic [15:0] mk_vec(int st, bit ll);
    logic [1:0] s;
    s = 2'(st);
    return {s, st >= 2, st == 1, st == 3, st == 3, ll, m_miss, 8'(m_retry)};
  endfunction

  task automatic push(int c, bit ll);
    logic [15:0] v;
    exp_t e;
    v = mk_vec(m_st, ll);
    if (v != m_last) begin
      e.cyc = c;
      e.vec = v;
      exp_q.push_back(e);
      m_last = v;
    end
  endtask

  task automatic enter_reset(int c, bit ll);
    m_st = 1;
    m_rst_end = c + RST;
    push(c, ll);
    if (ll) push(c + 1, 1'b0);
  endtask

  // Apply every timed event that becomes visible strictly before cycle v.
  task automatic m_advance(int v);
    bit busy;
    bit was_locked;
    busy = 1'b1;
    while (busy) begin
      busy = 1'b0;
      if (m_st == 1 && m_rst_end < v) begin
        m_st = 2; m_good = 0; m_tmr = 0; m_wd_base = m_rst_end;
        push(m_rst_end, 1'b0);
        busy = 1'b1;
      end else if (m_st >= 2 && m_wd_base + REF_TO < v) begin
        was_locked = (m_st == 3);
        m_miss = 1'b1;
        enter_reset(m_wd_base + REF_TO, was_locked);
        busy = 1'b1;
      end
    end
  endtask

  task automatic m_tick(int v, int e);
    int a;
    m_advance(v);
    a = (e < 0) ? -e : e;
    if (a > 127) a = 127;
    if (m_st == 2) begin
      m_wd_base = v;
      m_tmr++;
      m_good = (a <= LTH) ? m_good + 1 : 0;
      if (m_good == LCNT) begin
        m_st = 3; m_bad = 0;
        push(v, 1'b0);
      end else if (m_tmr == ACQ_TO) begin
        if (m_retry < 255) m_retry++;
        enter_reset(v, 1'b0);
      end
    end else if (m_st == 3) begin
      m_wd_base = v;
      m_bad = (a > UTH) ? m_bad + 1 : 0;
      if (m_bad == UCNT) begin
        m_st = 2; m_good = 0; m_tmr = 0;
        push(v, 1'b1);
        push(v + 1, 1'b0);
      end
    end
  endtask

  // Stimulus: inputs change 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    m_advance(cyc + 1);
  endtask

  task automatic idle(int n);
    repeat (n) step();
  endtask

  task automatic set_enable(bit b);
    enable_i = b;
    m_en = b;
    if (!b) begin
      m_st = 0;
      push(cyc + 1, 1'b0);
    end else if (m_st == 0) begin
      m_miss = 1'b0; m_retry = 0;
      enter_reset(cyc + 1, 1'b0);
    end
    step();
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    m_st = 0; m_miss = 1'b0; m_retry = 0;
    push(cyc + 1, 1'b0);
    step();
    step();
    reset_i = 1'b0;
    if (m_en) enter_reset(cyc + 1, 1'b0);
    step();
  endtask

  // One reference pulse (high for one cycle), period p cycles; its tick is
  // visible three cycles after the rising edge.
  task automatic tick(int e, int p);
    ref_clk_i = 1'b1;
    error_i = 8'(e);
    m_tick(cyc + 3, e);
    step();
    ref_clk_i = 1'b0;
    repeat (p - 1) step();
  endtask

  function automatic int rand_good();
    return int'($urandom_range(0, 8)) - 4;
  endfunction

  function automatic int rand_any();
    int r;
    r = int'($urandom_range(0, 5));
    if (r <= 2) return rand_good();
    if (r == 3) return int'($urandom_range(17, 127)) * (($urandom_range(0, 1) == 0) ? 1 : -1);
    if (r == 4) return -128;
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  function automatic int gap();
    return 4 + int'($urandom_range(0, 2));
  endfunction

  // Monitor: every change of the output vector must match the next
  // expected entry, both in value and in cycle.
  logic [15:0] prev = 16'h0;
  logic [15:0] cur;
  exp_t        mon_e;
  always @(negedge clk) begin
    cur = {state_o, adpll_enable_o, adpll_reset_o, gain_sel_o, locked_o,
           lock_lost_o, ref_missing_o, retry_cnt_o};
    if (cur !== prev) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_change cyc=%0d got=%h want=no change", cyc, cur);
      end else begin
        mon_e = exp_q.pop_front();
        if (cur !== mon_e.vec || cyc != mon_e.cyc) begin
          bad++;
          $display("FAIL output_event got cyc=%0d vec=%h want cyc=%0d vec=%h",
                   cyc, cur, mon_e.cyc, mon_e.vec);
        end
      end
    end
    prev = cur;
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset_i = 1'b0;
    @(negedge clk);
    total++;
    if ({state_o, adpll_enable_o, adpll_reset_o, gain_sel_o, locked_o,
         lock_lost_o, ref_missing_o, retry_cnt_o} !== 16'h0) begin
      bad++;
      $display("FAIL reset_state got state=%0d retry=%0d want all zero", state_o, retry_cnt_o);
    end
    step();

    // Bring-up: RESET_LOOP for 16 cycles, then ACQUIRE
    set_enable(1'b1);
    idle(20);

    // Clean lock
    repeat (LCNT) tick(3, 4);
    idle(3);

    // Bad burst shorter than the unlock count, then a full one
    repeat (3) tick(-20, 4);
    tick(0, 4);
    repeat (UCNT) tick(-20, 4);
    idle(3);

    // One bad sample at tick 10 restarts the good run
    repeat (9) tick(rand_good(), gap());
    tick(20, 4);
    repeat (LCNT) tick(rand_good(), gap());
    idle(3);

    // Most-negative error is a large magnitude; -4 is still good
    repeat (UCNT) tick(-128, 4);
    idle(3);
    repeat (LCNT) tick(-4, 4);
    idle(3);

    // Disable while LOCKED, then while in RESET_LOOP
    set_enable(1'b0);
    idle(3);
    set_enable(1'b1);
    idle(5);
    set_enable(1'b0);
    idle(3);
    set_enable(1'b1);
    idle(20);

    // Acquisition timeout
    repeat (ACQ_TO) tick(50, 3);
    idle(20);

    // Lock, then lose the reference
    repeat (LCNT) tick(rand_good(), 4);
    idle(REF_TO + 5);
    idle(20);

    // Reset in the middle of ACQUIRE
    repeat (3) tick(3, 4);
    do_reset();
    idle(20);

    // Random soak
    repeat (80) tick(rand_any(), 4 + int'($urandom_range(0, 3)));
    idle(10);
    set_enable(1'b0);
    idle(5);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_events got=%0d outstanding want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
